// File: rtl/perf_stat_pkg.sv
// Shared constants and sizing helpers for the performance-statistics display bank.
package perf_stat_pkg;

    // Default channel roles on the CPU board: external words first, then counters.
    localparam int CH_SYSCALL   = 0;
    localparam int CH_PC        = 1;
    localparam int CNT_CYCLE    = 0;
    localparam int CNT_JUMP     = 1;
    localparam int CNT_BRANCH   = 2;
    localparam int CNT_BR_TAKEN = 3;
    localparam int CNT_LOADUSE  = 4;
    localparam int CNT_MDATA    = 5;

    typedef enum logic {
        SRC_LIVE = 1'b0,
        SRC_SNAP = 1'b1
    } disp_src_e;

    function automatic int sel_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic int ext_bus_width(input int num_ext);
        return 32 * ((num_ext > 0) ? num_ext : 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear beats increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         ovf
);

    logic [W-1:0] value_q, value_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (en) begin
            if (&value_q) ovf_d = 1'b1;
            else          value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_stat_display.sv
// Statistics counter bank, freeze snapshot and manual/auto-scroll selector driving
// one registered 32-bit word to the 7-segment display.
module perf_stat_display
    import perf_stat_pkg::*;
#(
    parameter int NUM_CNT    = 6,
    parameter int NUM_EXT    = 2,
    parameter int CNT_W      = 32,
    parameter int SCROLL_DIV = 50_000_000,
    parameter int SEL_W      = sel_width(NUM_EXT + NUM_CNT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               halt,
    input  logic [NUM_CNT-1:0]                 inc,
    input  logic [ext_bus_width(NUM_EXT)-1:0]  ext_data,
    input  logic                               clr_stats,
    input  logic                               freeze,
    input  logic                               auto_mode,
    input  logic [SEL_W-1:0]                   sel,
    output logic [31:0]                        disp_out,
    output logic [SEL_W-1:0]                   disp_idx,
    output logic [NUM_CNT-1:0]                 ovf
);

    localparam int TOTAL = NUM_EXT + NUM_CNT;
    localparam int TMR_W = $clog2(SCROLL_DIV);

    logic [CNT_W-1:0] cnt_val [NUM_CNT];
    logic [31:0]      live    [TOTAL];
    logic [31:0]      snap_q  [TOTAL];
    logic             freeze_q;

    logic [TMR_W-1:0] timer_q, timer_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] src_idx;
    disp_src_e        src;
    logic [31:0]      disp_out_q, disp_out_d;
    logic [SEL_W-1:0] disp_idx_q;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr_stats),
            .en    (inc[g] & ~halt),
            .value (cnt_val[g]),
            .ovf   (ovf[g])
        );
    end

    always_comb begin
        for (int e = 0; e < NUM_EXT; e++) live[e] = ext_data[32*e +: 32];
        for (int c = 0; c < NUM_CNT; c++) live[NUM_EXT + c] = 32'(cnt_val[c]);
    end

    // Capture happens on the first cycle freeze is seen high, so increments in that cycle are excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_q <= 1'b0;
            // NOTE: the snapshot array is a plain register bank, so it can and does take the synchronous reset.
            for (int c = 0; c < TOTAL; c++) snap_q[c] <= '0;
        end else begin
            freeze_q <= freeze;
            if (freeze && !freeze_q) begin
                for (int c = 0; c < TOTAL; c++) snap_q[c] <= live[c];
            end
        end
    end

    // In manual mode idx tracks sel and the timer idles at 0, so entering auto resumes from the shown channel.
    always_comb begin
        timer_d = timer_q;
        idx_d   = idx_q;
        if (!auto_mode) begin
            timer_d = '0;
            idx_d   = sel;
        end else if (timer_q == TMR_W'(SCROLL_DIV - 1)) begin
            timer_d = '0;
            idx_d   = (int'(idx_q) >= TOTAL - 1) ? '0 : idx_q + SEL_W'(1);
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_comb begin
        src_idx    = auto_mode ? idx_q : sel;
        src        = (freeze && freeze_q) ? SRC_SNAP : SRC_LIVE;
        disp_out_d = '0;
        for (int c = 0; c < TOTAL; c++) begin
            if (src_idx == SEL_W'(c)) disp_out_d = (src == SRC_SNAP) ? snap_q[c] : live[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q    <= '0;
            idx_q      <= '0;
            disp_out_q <= '0;
            disp_idx_q <= '0;
        end else begin
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            disp_out_q <= disp_out_d;
            disp_idx_q <= src_idx;
        end
    end

    assign disp_out = disp_out_q;
    assign disp_idx = disp_idx_q;

endmodule

// File: tb/tb_perf_stat_display.sv
// Bench for perf_stat_display: directed scenarios plus randomized traffic against
// a behavioural model of what the display must show each cycle.
module tb_perf_stat_display;

    localparam int NC   = 5;
    localparam int NE   = 2;
    localparam int CW   = 8;
    localparam int DIV  = 4;
    localparam int SW   = 3;
    localparam int TOT  = NE + NC;
    localparam int MAXV = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            halt;
    logic [NC-1:0]   inc;
    logic [32*NE-1:0] ext_data;
    logic            clr_stats;
    logic            freeze;
    logic            auto_mode;
    logic [SW-1:0]   sel;
    logic [31:0]     disp_out;
    logic [SW-1:0]   disp_idx;
    logic [NC-1:0]   ovf;

    always #5 clk = ~clk;

    perf_stat_display #(
        .NUM_CNT    (NC),
        .NUM_EXT    (NE),
        .CNT_W      (CW),
        .SCROLL_DIV (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .inc       (inc),
        .ext_data  (ext_data),
        .clr_stats (clr_stats),
        .freeze    (freeze),
        .auto_mode (auto_mode),
        .sel       (sel),
        .disp_out  (disp_out),
        .disp_idx  (disp_idx),
        .ovf       (ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts per counter, snapshot of channel values, and scroll
    // position derived from the sel seen before auto mode plus elapsed auto cycles.
    int          m_cnt [NC];
    logic [NC-1:0] m_ovf;
    logic [31:0] m_snap [TOT];
    bit          m_frz_prev;
    int          m_last_sel;
    int          m_auto_cycles;
    int          m_src;
    logic [31:0] m_out;
    int          m_idx;
    bit          model_valid = 1'b0;

    function automatic logic [31:0] m_live(input int c);
        if (c < NE) return ext_data[32*c +: 32];
        return 32'(m_cnt[c - NE]);
    endfunction

    function automatic int scroll_pos(input int base, input int steps);
        int first;
        if (steps == 0) return base;
        first = (base >= TOT - 1) ? 0 : base + 1;
        return (first + steps - 1) % TOT;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) m_cnt[i] = 0;
            for (int c = 0; c < TOT; c++) m_snap[c] = '0;
            m_ovf         = '0;
            m_frz_prev    = 1'b0;
            m_last_sel    = 0;
            m_auto_cycles = 0;
            m_out         = '0;
            m_idx         = 0;
        end else begin
            m_src = auto_mode ? scroll_pos(m_last_sel, m_auto_cycles / DIV) : int'(sel);
            m_idx = m_src;
            if (m_src >= TOT)                m_out = '0;
            else if (freeze && m_frz_prev)   m_out = m_snap[m_src];
            else                             m_out = m_live(m_src);
            if (freeze && !m_frz_prev) begin
                for (int c = 0; c < TOT; c++) m_snap[c] = m_live(c);
            end
            for (int i = 0; i < NC; i++) begin
                if (clr_stats) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 1'b0;
                end else if (inc[i] && !halt) begin
                    if (m_cnt[i] == MAXV) m_ovf[i] = 1'b1;
                    else                  m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (auto_mode) m_auto_cycles++;
            else begin
                m_auto_cycles = 0;
                m_last_sel    = int'(sel);
            end
            m_frz_prev = freeze;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_disp_out", 64'(disp_out), 64'(m_out));
            check("model_disp_idx", 64'(disp_idx), 64'(m_idx));
            check("model_ovf", 64'(ovf), 64'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; inc = '0; ext_data = '0; clr_stats = 1'b0;
        freeze = 1'b0; auto_mode = 1'b0; sel = '0;
        tick(3);
        model_valid = 1'b1;
        check("reset_disp_out", 64'(disp_out), 64'h0);
        check("reset_disp_idx", 64'(disp_idx), 64'h0);
        check("reset_ovf", 64'(ovf), 64'h0);
        rst = 1'b0;

        // Counter 0 on channel 2: ten counts, then halted increments are ignored.
        sel = 3'd2; inc = 5'b00001;
        tick(10);
        inc = '0;
        tick(1);
        check("cnt0_ten", 64'(disp_out), 64'd10);
        halt = 1'b1; inc = 5'b00001;
        tick(5);
        halt = 1'b0; inc = '0;
        tick(1);
        check("cnt0_halted", 64'(disp_out), 64'd10);

        // Counter 1 saturates at 255, then clear wins over a same-cycle increment.
        sel = 3'd3; inc = 5'b00010;
        tick(300);
        inc = '0;
        tick(1);
        check("cnt1_saturated", 64'(disp_out), 64'd255);
        check("cnt1_ovf_set", 64'(ovf[1]), 64'd1);
        clr_stats = 1'b1; inc = 5'b00010;
        tick(1);
        clr_stats = 1'b0; inc = '0;
        check("cnt1_ovf_cleared", 64'(ovf), 64'h0);
        tick(1);
        check("cnt1_cleared", 64'(disp_out), 64'd0);

        // External words and an out-of-range index.
        ext_data = {32'h0040_0010, 32'hDEAD_BEEF};
        sel = 3'd0;
        tick(1);
        check("ext0", 64'(disp_out), 64'hDEAD_BEEF);
        sel = 3'd1;
        tick(1);
        check("ext1", 64'(disp_out), 64'h0040_0010);
        sel = 3'd7;
        tick(1);
        check("oob_disp_out", 64'(disp_out), 64'h0);
        check("oob_disp_idx", 64'(disp_idx), 64'd7);

        // Freeze at 100 while 50 more counts arrive, then release.
        sel = 3'd4; inc = 5'b00100;
        tick(100);
        inc = '0; freeze = 1'b1;
        tick(1);
        inc = 5'b00100;
        tick(50);
        check("frozen_100", 64'(disp_out), 64'd100);
        freeze = 1'b0; inc = '0;
        tick(1);
        check("unfrozen_150", 64'(disp_out), 64'd150);

        // Auto scroll from channel 5: 6, then wrap to 0, then 1 at 4-cycle spacing.
        sel = 3'd5;
        tick(1);
        auto_mode = 1'b1;
        tick(4);
        check("scroll_hold5", 64'(disp_idx), 64'd5);
        tick(1);
        check("scroll_to6", 64'(disp_idx), 64'd6);
        tick(4);
        check("scroll_wrap0", 64'(disp_idx), 64'd0);
        tick(4);
        check("scroll_to1", 64'(disp_idx), 64'd1);

        // Reset mid-scroll with live counters nonzero.
        rst = 1'b1;
        tick(1);
        check("midrst_disp_out", 64'(disp_out), 64'h0);
        check("midrst_disp_idx", 64'(disp_idx), 64'h0);
        check("midrst_ovf", 64'(ovf), 64'h0);
        rst = 1'b0; auto_mode = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            halt      = ($urandom_range(0, 7) == 0);
            inc       = NC'($urandom);
            clr_stats = ($urandom_range(0, 399) == 0);
            sel       = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) freeze = ~freeze;
            if ($urandom_range(0, 29) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 3) == 0) ext_data = {$urandom, $urandom};
            tick(1);
        end

        rst = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
